fetch_queue_stage: RTL and testbench
====================================

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 Parameter XLEN, default 32, width of PC and addresses.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter IMEM_WORDS, default 256, instruction memory size in 32-bit words.
REQ-004 Parameter FQ_DEPTH, default 4, fetch-queue entries (power of two, >=2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 imem_addr  output  XLEN  byte address presented to combinational-read instruction memory (current PC).
REQ-008 imem_rdata  input  32  instruction word returned same cycle for imem_addr.
REQ-009 redirect_valid  input  1  branch/jump taken (PCSrc or JumpReg resolved downstream).
REQ-010 redirect_target  input  XLEN  new PC on redirect.
REQ-011 out_valid  output  1  queue head holds a valid entry.
REQ-012 out_ready  input  1  decode accepts head this cycle.
REQ-013 out_instr  output  32  head instruction.
REQ-014 out_pc  output  XLEN  head PC.
REQ-015 out_pc_plus4  output  XLEN  head PC + 4, modulo 2^XLEN.
REQ-016 out_fault  output  1  head entry is an out-of-range fetch marker.
REQ-017 fq_count  output  $clog2(FQ_DEPTH)+1  current occupancy.

Function
REQ-018 States: FETCH, HALTED; reset enters FETCH.
REQ-019 imem_addr shall equal PC combinationally; PC[1:0] always 00.
REQ-020 In FETCH, no redirect, and space available (count<FQ_DEPTH, or count==FQ_DEPTH with pop this cycle), push {PC, imem_rdata, fault=0} and PC<=PC+4.
REQ-021 Pop occurs when out_valid && out_ready; head advances one entry, no bubble.
REQ-022 Push and pop in the same cycle leave count unchanged, including at full and at count==1.
REQ-023 Full with no pop: no push, PC holds, imem_addr stable.
REQ-024 Empty: out_valid=0; out_instr/out_pc/out_fault are don't-care but fault shall not be 1 with out_valid=0.
REQ-025 Fetch latency: instruction at PC becomes visible at head the cycle after push (registered queue, no fall-through).
REQ-026 If PC >= IMEM_WORDS*4 in FETCH with space, push one entry {PC, 32'h0000_0013, fault=1} and enter HALTED; PC holds.
REQ-027 HALTED: no pushes; queue continues to drain; leaves only on redirect.
REQ-028 redirect_valid=1 (any state): flush all entries (count<=0), PC<=redirect_target with bits [1:0] cleared, state<=FETCH, no push that cycle; a simultaneous pop is discarded.
REQ-029 Redirect has priority over push, pop and halt entry.
REQ-030 Read/write pointers wrap modulo FQ_DEPTH.
REQ-031 PC+4 overflow wraps modulo 2^XLEN and is then subject to REQ-026.

Reset
REQ-032 While rst=0: PC=RESET_PC, state=FETCH, count=0, out_valid=0, out_fault=0, pointers=0; effect is immediate, independent of clk.
REQ-033 Reset asserted mid-operation discards all queued entries; first push after release fetches RESET_PC.
REQ-034 First push occurs on the first rising edge with rst=1.

Verification
REQ-035 Reset release, out_ready=1, memory word[i]=i -> out_pc 0,4,8,... each cycle from cycle 2, out_instr 0,1,2, count steady at 1.
REQ-036 out_ready=0 for 6 cycles, FQ_DEPTH=4 -> count reaches 4, imem_addr frozen at 0x10; out_ready=1 -> pcs 0x0,0x4,0x8,0xC,0x10 in order, no gap.
REQ-037 Queue full plus redirect_valid=1, target 0x43 -> next cycle count=0, out_valid=0, imem_addr=0x40; following cycle head pc=0x40.
REQ-038 IMEM_WORDS=4, out_ready=0 after reset -> entries pc 0x0-0xC fault=0; then out_ready=1, drain, one entry pc=0x10 fault=1 instr=0x13; then out_valid=0, no further pushes.
REQ-039 In HALTED, redirect to 0x8 -> state FETCH, next head pc=0x8 fault=0.
REQ-040 rst pulsed low mid-stream between clock edges -> out_valid=0 immediately; after release, first head pc=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_stage_if.sv
// Bundles the instruction-memory, redirect and decode-side handshake signals of the fetch stage.
// The master modport is the fetch stage; the slave side belongs to memory/decode.
interface fetch_queue_stage_if #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      imem_rdata;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_pc_plus4;
  logic             out_fault;
  logic [CNT_W-1:0] fq_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output out_fault,
    output fq_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  out_fault,
    input  fq_count
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: walks the PC through a combinational-read memory and buffers
// {pc, instr, fault} entries in a registered FIFO; out-of-range fetches halt until redirected.
module fetch_queue_stage #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 256,
  parameter int              FQ_DEPTH   = 4
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_stage_if.master bus
);
  localparam int              PTR_W       = $clog2(FQ_DEPTH);
  localparam int              CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FQ_DEPTH);
  localparam logic [XLEN:0]   IMEM_BYTES  = (XLEN+1)'(IMEM_WORDS * 4);
  localparam logic [XLEN-1:0] PC_MASK     = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [31:0]     FAULT_INSTR = 32'h0000_0013;

  typedef enum logic {FETCH, HALTED} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } entry_t;

  state_t                     state_q, state_d;
  logic [XLEN-1:0]            pc_q, pc_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  entry_t [FQ_DEPTH-1:0]      entries_q, entries_d;

  logic   pop;
  logic   push;
  logic   has_space;
  logic   in_range;
  entry_t head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC & PC_MASK;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      entries_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      entries_q <= entries_d;
    end
  end

  // Redirect wins over everything: it flushes the queue, discarding any same-cycle pop or push.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    entries_d = entries_q;
    push      = 1'b0;
    pop       = (count_q != '0) && bus.out_ready;
    has_space = (count_q != FULL_CNT) || pop;
    in_range  = {1'b0, pc_q} < IMEM_BYTES;

    if (bus.redirect_valid) begin
      state_d  = FETCH;
      pc_d     = bus.redirect_target & PC_MASK;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (state_q == FETCH && has_space) begin
        push = 1'b1;
        if (in_range) begin
          entries_d[wr_ptr_q] = '{pc: pc_q, instr: bus.imem_rdata, fault: 1'b0};
          pc_d                = pc_q + XLEN'(4);
        end else begin
          entries_d[wr_ptr_q] = '{pc: pc_q, instr: FAULT_INSTR, fault: 1'b1};
          state_d             = HALTED;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fault is gated with valid so a stale head entry can never signal a fault while empty.
  assign head             = entries_q[rd_ptr_q];
  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc + XLEN'(4);
  assign bus.out_fault    = (count_q != '0) && head.fault;
  assign bus.fq_count     = count_q;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the fetch rules.
module tb_fetch_queue_stage;
  localparam int          XLEN       = 32;
  localparam int          IMEM_WORDS = 32;
  localparam int          FQ_DEPTH   = 4;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam logic [31:0] IMEM_BYTES = IMEM_WORDS * 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [IMEM_WORDS];
  ent_t        mq [$];
  logic [31:0] mpc;
  bit          mhalted;

  fetch_queue_stage_if #(.XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH)) bus ();

  fetch_queue_stage #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS), .FQ_DEPTH(FQ_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (bus.imem_addr < IMEM_BYTES) bus.imem_rdata = mem[bus.imem_addr[6:2]];
    else                            bus.imem_rdata = 32'hDEAD_BEEF;
  end

  // Reference model: an ordered list of fetched entries plus the next PC and a halted flag.
  task automatic model_reset();
    mq.delete();
    mpc     = RESET_PC;
    mhalted = 0;
  endtask

  task automatic model_step();
    bit   pop_now;
    bit   space;
    ent_t e;
    if (bus.redirect_valid) begin
      mq.delete();
      mpc     = bus.redirect_target & ~32'h3;
      mhalted = 0;
    end else begin
      pop_now = (mq.size() > 0) && bus.out_ready;
      space   = (mq.size() < FQ_DEPTH) || pop_now;
      if (pop_now) void'(mq.pop_front());
      if (!mhalted && space) begin
        if (mpc < IMEM_BYTES) begin
          e = '{pc: mpc, instr: mem[mpc[6:2]], fault: 1'b0};
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end else begin
          e = '{pc: mpc, instr: 32'h13, fault: 1'b1};
          mq.push_back(e);
          mhalted = 1;
        end
      end
    end
  endtask

  function automatic ent_t mhead();
    if (mq.size() > 0) return mq[0];
    return '0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = target;
    cycle();
    bus.redirect_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.fq_count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.fq_count); end
    checks++; if (bus.out_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.out_fault); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc i=%0d got=%h exp=%h", i, bus.out_pc, 32'(i * 4)); end
      checks++; if (bus.out_instr !== mhead().instr) begin errors++; $display("FAIL stream_instr i=%0d got=%h exp=%h", i, bus.out_instr, mhead().instr); end
      checks++; if (bus.fq_count !== 1) begin errors++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, bus.fq_count); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (bus.fq_count !== mq.size()) begin errors++; $display("FAIL bp_count i=%0d got=%0d exp=%0d", i, bus.fq_count, mq.size()); end
    end
    checks++; if (bus.fq_count !== FQ_DEPTH) begin errors++; $display("FAIL bp_full got=%0d exp=%0d", bus.fq_count, FQ_DEPTH); end
    checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL bp_addr got=%h exp=00000010", bus.imem_addr); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k * 4)) begin errors++; $display("FAIL bp_drain k=%0d got=%h exp=%h", k, bus.out_pc, 32'(k * 4)); end
      cycle();
    end
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (bus.fq_count !== FQ_DEPTH) begin errors++; $display("FAIL redir_prefull got=%0d exp=%0d", bus.fq_count, FQ_DEPTH); end
    bus.out_ready = 1'b1;
    redirect_to(32'h43);
    bus.out_ready = 1'b0;
    checks++; if (bus.fq_count !== 0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%0d/%b exp=0/0", bus.fq_count, bus.out_valid); end
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=00000040", bus.imem_addr); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_fault !== 1'b0) begin errors++; $display("FAIL redir_head got=%h/%b exp=00000040/0", bus.out_pc, bus.out_fault); end
    checks++; if (bus.out_instr !== mem[16]) begin errors++; $display("FAIL redir_instr got=%h exp=%h", bus.out_instr, mem[16]); end
  endtask

  task automatic test_halt();
    bus.out_ready = 1'b0;
    redirect_to(32'h70);
    for (int i = 0; i < 4; i++) cycle();
    checks++; if (bus.fq_count !== 4 || bus.imem_addr !== 32'h80) begin errors++; $display("FAIL halt_fill got=%0d/%h exp=4/00000080", bus.fq_count, bus.imem_addr); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_pc !== 32'h70 + 32'(4 * k) || bus.out_fault !== 1'b0) begin errors++; $display("FAIL halt_drain k=%0d got=%h/%b exp=%h/0", k, bus.out_pc, bus.out_fault, 32'h70 + 32'(4 * k)); end
      cycle();
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80 || bus.out_fault !== 1'b1) begin errors++; $display("FAIL halt_marker got=%b/%h/%b exp=1/00000080/1", bus.out_valid, bus.out_pc, bus.out_fault); end
    checks++; if (bus.out_instr !== 32'h13 || bus.out_pc_plus4 !== 32'h84) begin errors++; $display("FAIL halt_instr got=%h/%h exp=00000013/00000084", bus.out_instr, bus.out_pc_plus4); end
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_valid !== 1'b0 || bus.out_fault !== 1'b0 || bus.imem_addr !== 32'h80) begin errors++; $display("FAIL halt_idle k=%0d got=%b/%b/%h exp=0/0/00000080", k, bus.out_valid, bus.out_fault, bus.imem_addr); end
      cycle();
    end
  endtask

  task automatic test_halt_redirect();
    bus.out_ready = 1'b1;
    redirect_to(32'h8);
    checks++; if (bus.fq_count !== 0 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL hredir_flush got=%0d/%h exp=0/00000008", bus.fq_count, bus.imem_addr); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8 || bus.out_fault !== 1'b0 || bus.out_instr !== mem[2]) begin errors++; $display("FAIL hredir_head got=%h/%b/%h exp=00000008/0/%h", bus.out_pc, bus.out_fault, bus.out_instr, mem[2]); end
    redirect_to(32'hFFFF_FFFF);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.imem_addr); end
    cycle();
    checks++; if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_fault !== 1'b1 || bus.out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_head got=%h/%b/%h exp=fffffffc/1/00000000", bus.out_pc, bus.out_fault, bus.out_pc_plus4); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    redirect_to(32'h20);
    for (int i = 0; i < 3; i++) cycle();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.fq_count !== 0 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL areset_now got=%b/%0d/%h exp=0/0/%h", bus.out_valid, bus.fq_count, bus.imem_addr, RESET_PC); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin errors++; $display("FAIL areset_first got=%b/%h exp=1/%h", bus.out_valid, bus.out_pc, RESET_PC); end
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bus.redirect_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           bus.redirect_target = 32'($urandom_range(0, 160));
      cycle();
      h = mhead();
      checks++; if (bus.out_valid !== (mq.size() > 0) || bus.fq_count !== mq.size() || bus.imem_addr !== mpc) begin errors++; $display("FAIL rand_state n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, bus.out_valid, bus.fq_count, bus.imem_addr, mq.size() > 0, mq.size(), mpc); end
      if (mq.size() > 0) begin
        checks++; if (bus.out_pc !== h.pc || bus.out_instr !== h.instr || bus.out_fault !== h.fault || bus.out_pc_plus4 !== h.pc + 32'd4) begin errors++; $display("FAIL rand_head n=%0d got=%h/%h/%b exp=%h/%h/%b", n, bus.out_pc, bus.out_instr, bus.out_fault, h.pc, h.instr, h.fault); end
      end else begin
        checks++; if (bus.out_fault !== 1'b0) begin errors++; $display("FAIL rand_empty_fault n=%0d got=%b exp=0", n, bus.out_fault); end
      end
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    rst                 = 1'b0;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = i;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
